// File: rtl/control_pkg.sv
// Shared encodings for the fetch/execute control sequencer: states, opcode fields and strobe bundles.
package control_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [1:0] OP_MOV = 2'd0;
    localparam logic [1:0] OP_JMP = 2'd1;
    localparam logic [1:0] OP_JZ  = 2'd2;
    localparam logic [1:0] OP_HLT = 2'd3;

    localparam logic [1:0] SRC_A   = 2'd0;
    localparam logic [1:0] SRC_X   = 2'd1;
    localparam logic [1:0] SRC_ALU = 2'd2;
    localparam logic [1:0] SRC_MEM = 2'd3;

    localparam logic [1:0] DST_A = 2'd0;
    localparam logic [1:0] DST_B = 2'd1;
    localparam logic [1:0] DST_X = 2'd2;
    localparam logic [1:0] DST_Q = 2'd3;

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] rsvd;
        logic [1:0] src;
        logic [1:0] dst;
    } ir_t;

    // Active-low bus enables; all ones means nobody drives dbus.
    typedef struct packed {
        logic a;
        logic x;
        logic alu;
        logic rom;
    } assert_bar_t;

    typedef struct packed {
        logic a;
        logic b;
        logic x;
        logic q;
    } trigger_t;

    function automatic trigger_t dst_onehot(input logic [1:0] dst);
        trigger_t t;
        t = '0;
        case (dst)
            DST_A:   t.a = 1'b1;
            DST_B:   t.b = 1'b1;
            DST_X:   t.x = 1'b1;
            default: t.q = 1'b1;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter with async reset to RESET_PC; load beats increment, arithmetic wraps modulo 2^PC_W.
// Next value visible one clock after load/inc; no backpressure.
module pc_counter #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Two-cycle fetch/execute microsequencer driving one dbus source and at most one register load per cycle.
// Optional CONTROL_STEP_EN adds a step input that stalls FETCH until step is sampled high.
module control_sequencer
    import control_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clkBar,
    input  logic            resetBar,
    input  logic [7:0]      dbus,
    input  logic            alu_zero,
`ifdef CONTROL_STEP_EN
    input  logic            step,
`endif
    output logic            trigger_a,
    output logic            trigger_b,
    output logic            trigger_x,
    output logic            trigger_q,
    output logic            assert_bar_a,
    output logic            assert_bar_x,
    output logic            assert_bar_alu,
    output logic            assert_bar_rom,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    state_t      state_q;
    state_t      state_d;
    ir_t         ir_q;
    logic        zflag_q;
    logic        ir_load;
    logic        z_load;
    logic        pc_load;
    logic        pc_inc;
    logic        step_ok;
    assert_bar_t ab;
    trigger_t    trig;
    logic [1:0]  ir_unused;

    assign ir_unused = ir_q.rsvd;

`ifdef CONTROL_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    pc_counter #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clkBar),
        .rst_n    (resetBar),
        .load     (pc_load),
        .inc      (pc_inc),
        .load_val (PC_W'(dbus)),
        .pc       (pc)
    );

    always_ff @(posedge clkBar or negedge resetBar) begin
        if (!resetBar) begin
            state_q <= FETCH;
            ir_q    <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ir_load) begin
                ir_q <= ir_t'(dbus);
            end
            if (z_load) begin
                zflag_q <= alu_zero;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ab      = '1;
        trig    = '0;
        ir_load = 1'b0;
        z_load  = 1'b0;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        case (state_q)
            FETCH: begin
                // ROM stays on the bus while stalled so dbus never floats.
                ab.rom = 1'b0;
                if (step_ok) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                case (ir_q.op)
                    OP_MOV: begin
                        trig = dst_onehot(ir_q.dst);
                        case (ir_q.src)
                            SRC_A:   ab.a = 1'b0;
                            SRC_X:   ab.x = 1'b0;
                            SRC_ALU: begin
                                ab.alu = 1'b0;
                                z_load = 1'b1;
                            end
                            default: begin
                                ab.rom = 1'b0;
                                pc_inc = 1'b1;
                            end
                        endcase
                    end
                    OP_JMP: begin
                        ab.rom  = 1'b0;
                        pc_load = 1'b1;
                    end
                    OP_JZ: begin
                        ab.rom  = 1'b0;
                        pc_load = zflag_q;
                        pc_inc  = !zflag_q;
                    end
                    default: state_d = HALT;
                endcase
            end
            HALT: state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Reset overrides the decode so nothing drives or loads while resetBar is low.
    assign trigger_a      = resetBar & trig.a;
    assign trigger_b      = resetBar & trig.b;
    assign trigger_x      = resetBar & trig.x;
    assign trigger_q      = resetBar & trig.q;
    assign assert_bar_a   = !resetBar | ab.a;
    assign assert_bar_x   = !resetBar | ab.x;
    assign assert_bar_alu = !resetBar | ab.alu;
    assign assert_bar_rom = !resetBar | ab.rom;
    assign halted         = (state_q == HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized + directed bench for control_sequencer against an instruction-level reference model.
module tb_control_sequencer;

    logic       clkBar   = 1'b0;
    logic       resetBar = 1'b0;
    logic [7:0] dbus;
    logic       alu_zero;
`ifdef CONTROL_STEP_EN
    logic       step = 1'b1;
`endif
    logic       trigger_a, trigger_b, trigger_x, trigger_q;
    logic       assert_bar_a, assert_bar_x, assert_bar_alu, assert_bar_rom;
    logic [7:0] pc;
    logic       halted;

    logic [7:0] rom [256];
    logic [7:0] rf [4] = '{default: 8'h00};
    logic [7:0] alu_val = 8'h01;

    logic [7:0] m_reg [4] = '{default: 8'h00};
    logic [7:0] m_pc;
    logic       m_z;
    logic       m_halt;

    int checks = 0;
    int errors = 0;

    logic [3:0] ab_vec;
    logic [3:0] tr_vec;

    control_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clkBar         (clkBar),
        .resetBar       (resetBar),
        .dbus           (dbus),
        .alu_zero       (alu_zero),
`ifdef CONTROL_STEP_EN
        .step           (step),
`endif
        .trigger_a      (trigger_a),
        .trigger_b      (trigger_b),
        .trigger_x      (trigger_x),
        .trigger_q      (trigger_q),
        .assert_bar_a   (assert_bar_a),
        .assert_bar_x   (assert_bar_x),
        .assert_bar_alu (assert_bar_alu),
        .assert_bar_rom (assert_bar_rom),
        .pc             (pc),
        .halted         (halted)
    );

    always #5 clkBar = ~clkBar;

    assign alu_zero = (alu_val == 8'h00);
    assign ab_vec   = {assert_bar_a, assert_bar_x, assert_bar_alu, assert_bar_rom};
    assign tr_vec   = {trigger_a, trigger_b, trigger_x, trigger_q};

    // Bus and register file surrounding the sequencer (indices 0..3 = A, B, X, Q).
    always_comb begin
        dbus = 8'h00;
        if (!assert_bar_rom)      dbus = rom[pc];
        else if (!assert_bar_a)   dbus = rf[0];
        else if (!assert_bar_x)   dbus = rf[2];
        else if (!assert_bar_alu) dbus = alu_val;
    end

    always @(posedge clkBar) begin
        if (trigger_a) rf[0] <= dbus;
        if (trigger_b) rf[1] <= dbus;
        if (trigger_x) rf[2] <= dbus;
        if (trigger_q) rf[3] <= dbus;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_reg%0d", tag, i), rf[i], m_reg[i]);
    endtask

    // Enter with resetBar low or high; leaves 1ns after a rising edge with the DUT in FETCH.
    task automatic do_reset();
        resetBar = 1'b0;
        repeat (2) @(posedge clkBar);
        @(negedge clkBar);
        chk("rst_pc", pc, 8'h00);
        chk("rst_halted", halted, 1'b0);
        chk("rst_trig", tr_vec, 4'b0000);
        chk("rst_ab", ab_vec, 4'b1111);
        @(posedge clkBar);
        #1 resetBar = 1'b1;
        m_pc   = 8'h00;
        m_z    = 1'b0;
        m_halt = 1'b0;
    endtask

    // Architectural effect of one instruction, then cycle-level checks of FETCH and EXEC.
    task automatic run_instr(input logic [7:0] alu);
        logic [7:0] op, opnd, pc0, val;
        logic [3:0] exp_ab, exp_tr;
        alu_val = alu;
        pc0     = m_pc;
        op      = rom[m_pc];
        m_pc    = m_pc + 8'd1;
        opnd    = rom[m_pc];
        exp_ab  = 4'b1110;
        exp_tr  = 4'b0000;
        case (op[7:6])
            2'd0: begin
                exp_tr = 4'b1000 >> op[1:0];
                exp_ab = ~(4'b1000 >> op[3:2]);
                case (op[3:2])
                    2'd0: val = m_reg[0];
                    2'd1: val = m_reg[2];
                    2'd2: begin val = alu; m_z = (alu == 8'h00); end
                    default: begin val = opnd; m_pc = m_pc + 8'd1; end
                endcase
                m_reg[op[1:0]] = val;
            end
            2'd1: m_pc = opnd;
            2'd2: m_pc = m_z ? opnd : m_pc + 8'd1;
            default: begin exp_ab = 4'b1111; m_halt = 1'b1; end
        endcase
        @(negedge clkBar);
        chk("fetch_ab", ab_vec, 4'b1110);
        chk("fetch_trig", tr_vec, 4'b0000);
        chk("fetch_pc", pc, pc0);
        @(negedge clkBar);
        chk($sformatf("exec_ab_op%0h", op), ab_vec, exp_ab);
        chk($sformatf("exec_trig_op%0h", op), tr_vec, exp_tr);
        @(posedge clkBar);
        #1;
        chk("pc_after", pc, m_pc);
        chk("halted_after", halted, m_halt);
        check_regs("after");
    endtask

    task automatic check_halt_hold();
        for (int i = 0; i < 4; i++) begin
            @(negedge clkBar);
            chk("halt_ab", ab_vec, 4'b1111);
            chk("halt_trig", tr_vec, 4'b0000);
            chk("halt_pc", pc, m_pc);
            chk("halt_flag", halted, 1'b1);
        end
        @(posedge clkBar);
        #1;
    endtask

    initial begin
        logic [7:0] b;
        int n;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;

        // Directed program: MOV, MOV imm, ALU->Q + JZ taken/not taken, JMP FF, wrap, HLT.
        rom[8'h00] = 8'h01;
        rom[8'h01] = 8'h0E; rom[8'h02] = 8'h5A;
        rom[8'h03] = 8'h0B;
        rom[8'h04] = 8'h80; rom[8'h05] = 8'h40;
        rom[8'h40] = 8'h0B;
        rom[8'h41] = 8'h80; rom[8'h42] = 8'h10;
        rom[8'h43] = 8'h40; rom[8'h44] = 8'hFF;
        rom[8'hFF] = 8'h01;
        do_reset();
        run_instr(8'h11);
        chk("movab_pc", pc, 8'h01);
        run_instr(8'h11);
        chk("movmem_x", rf[2], 8'h5A);
        chk("movmem_pc", pc, 8'h03);
        run_instr(8'h00);
        run_instr(8'h22);
        chk("jz_taken_pc", pc, 8'h40);
        run_instr(8'h3C);
        run_instr(8'h33);
        chk("jz_skip_pc", pc, 8'h43);
        run_instr(8'h44);
        chk("jmp_pc", pc, 8'hFF);
        rom[8'h00] = 8'hC0;
        run_instr(8'h55);
        chk("wrap_pc", pc, 8'h00);
        run_instr(8'h66);
        chk("hlt_halted", halted, 1'b1);
        check_halt_hold();

        // Reset asserted in EXEC of MOV MEM->X must abort without loading X.
        rom[8'h00] = 8'h0E; rom[8'h01] = 8'h77;
        do_reset();
        @(negedge clkBar);
        @(negedge clkBar);
        resetBar = 1'b0;
        #1;
        chk("abort_trig", tr_vec, 4'b0000);
        chk("abort_ab", ab_vec, 4'b1111);
        @(posedge clkBar);
        #1;
        chk("abort_x", rf[2], m_reg[2]);
        chk("abort_pc", pc, 8'h00);
        do_reset();
        run_instr(8'h01);
        chk("refetch_x", rf[2], 8'h77);

`ifdef CONTROL_STEP_EN
        rom[8'h00] = 8'h0E; rom[8'h01] = 8'h22;
        step = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clkBar);
            chk("stall_pc", pc, 8'h00);
            chk("stall_ab", ab_vec, 4'b1110);
            chk("stall_trig", tr_vec, 4'b0000);
        end
        step = 1'b1;
        @(posedge clkBar);
        #1 step = 1'b0;
        @(negedge clkBar);
        chk("step_exec_trig", tr_vec, 4'b0010);
        @(posedge clkBar);
        #1;
        chk("step_pc", pc, 8'h02);
        chk("step_x", rf[2], 8'h22);
        m_reg[2] = 8'h22;
        m_pc     = 8'h02;
        for (int i = 0; i < 3; i++) begin
            @(negedge clkBar);
            chk("step_hold_pc", pc, 8'h02);
        end
        step = 1'b1;
        @(posedge clkBar);
        #1;
        do_reset();
`endif

        // Random programs with rare HLT bytes.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 256; i++) begin
                b = 8'($urandom_range(0, 255));
                if (b[7:6] == 2'd3 && $urandom_range(0, 7) != 0) b[7:6] = 2'($urandom_range(0, 2));
                rom[i] = b;
            end
            do_reset();
            n = 0;
            while (!m_halt && n < 150) begin
                run_instr(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
                n++;
            end
            if (m_halt) check_halt_hold();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
